// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU and the multi-cycle multiplier
// sequencer that borrows it.
//   - ALU_* : ALUControl encodings understood by the datapath ALU
//   - mul_state_t : multiplier sequencer states
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ITER,
        MS_DONE
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational datapath ALU shared by the pipeline and the multiplier
// sequencer.
//   a, b        in  N  operands
//   ALUControl  in  4  operation select (see alu_pkg)
//   result      out N  operation result, mod 2^N
//   zero        out 1  result == 0
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic [N-1:0] result,
    output logic         zero
);

    // Unknown encodings produce zero so the result is always defined.
    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mul_iter_counter.sv
// ---------------------------------------------------------------------------
// mul_iter_counter
// Iteration counter for the shift-add multiplier. Counts ITER cycles and flags
// the final one (count == N-1). It is $clog2(N) bits wide; the sequencer
// always leaves ITER on the terminal cycle, so the count never wraps.
//   clk_i     in  1  clock
//   reset_i   in  1  asynchronous active-high reset
//   clear_i   in  1  restart the count at zero (has priority over enable)
//   enable_i  in  1  advance the count by one
//   last_o    out 1  current count is N-1
// ---------------------------------------------------------------------------
module mul_iter_counter
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic last_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == W'(N - 1));

endmodule

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
// Multi-cycle unsigned shift-add multiplier. It owns no adder: each ITER cycle
// it drives the shared EX-stage ALU with acc + (mplier[0] ? mcand : 0) and
// captures the ALU result as the new accumulator. The hazard unit stalls the
// pipeline while busy is high.
//
// Optional feature macro: ALU_MUL_EARLY_TERM_EN
//   defined   : leave ITER once the remaining multiplier bits are all zero;
//               op_b == 0 skips ITER entirely.
//   undefined : always N ITER cycles, latency N+1.
//
// Ports
//   clk          in  1  rising-edge clock
//   reset        in  1  asynchronous active-high reset
//   start        in  1  request, sampled only in IDLE
//   op_a, op_b   in  N  multiplicand / multiplier, captured on accept
//   busy         out 1  high from the cycle after accept until done
//   done         out 1  one-cycle pulse, product valid
//   product      out N  low N bits of op_a*op_b, held until next result
//   product_zero out 1  ALU zero flag from the final accumulate
//   alu_a/alu_b  out N  ALU operands
//   alu_ctrl     out 4  ALU operation select
//   alu_result   in  N  ALU result
//   alu_zero     in  1  ALU zero flag
// ---------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic         product_zero,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero
);

    mul_state_t   state_q;
    logic [N-1:0] acc_q;
    logic [N-1:0] mcand_q;
    logic [N-1:0] mplier_q;
    logic [N-1:0] mplier_d;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] product_q;
    logic         productZero_q;

    logic cntClear;
    logic cntEnable;
    logic cntLast;
    logic iterLast;
    logic startSkip;

    assign mplier_d  = mplier_q >> 1;
    assign cntClear  = (state_q == MS_IDLE) && start;
    assign cntEnable = (state_q == MS_ITER);

    mul_iter_counter #(
        .N(N)
    ) uIterCounter (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (cntClear),
        .enable_i(cntEnable),
        .last_o  (cntLast)
    );

    // With early termination, the run ends as soon as no set multiplier bits
    // remain; the counter's terminal flag still bounds the run at N cycles.
`ifdef ALU_MUL_EARLY_TERM_EN
    assign iterLast  = cntLast || (mplier_d == '0);
    assign startSkip = (op_b == '0);
`else
    assign iterLast  = cntLast;
    assign startSkip = 1'b0;
`endif

    // ALU drive: add the (possibly gated) multiplicand into the accumulator
    // while iterating; otherwise present a harmless AND of zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_AND;
        if (state_q == MS_ITER) begin
            alu_a    = acc_q;
            alu_b    = mplier_q[0] ? mcand_q : '0;
            alu_ctrl = ALU_ADD;
        end
    end

    // Sequencer FSM with datapath and registered status outputs. The result
    // registers load on the edge that enters DONE, so product is valid in the
    // same cycle done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= MS_IDLE;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            product_q     <= '0;
            productZero_q <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        if (startSkip) begin
                            state_q       <= MS_DONE;
                            done_q        <= 1'b1;
                            product_q     <= '0;
                            productZero_q <= 1'b1;
                        end else begin
                            state_q <= MS_ITER;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                MS_ITER: begin
                    acc_q    <= alu_result;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    if (iterLast) begin
                        state_q       <= MS_DONE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        product_q     <= alu_result;
                        productZero_q <= alu_zero;
                    end
                end
                MS_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= MS_IDLE;
                end
                default: begin
                    state_q <= MS_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign product      = product_q;
    assign product_zero = productZero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Bench for the shift-add multiplier sequencer wired to the real ALU.
// Expected results come from plain 64-bit multiplication and an iteration
// count derived from the multiplier's most significant set bit.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    localparam int N = 64;

`ifdef ALU_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] opA;
    logic [N-1:0] opB;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         productZero;
    logic [N-1:0] aluA;
    logic [N-1:0] aluB;
    logic [3:0]   aluCtrl;
    logic [N-1:0] aluResult;
    logic         aluZero;

    int testsRun;
    int testsFailed;

    alu_mul_sequencer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (opA),
        .op_b        (opB),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .product_zero(productZero),
        .alu_a       (aluA),
        .alu_b       (aluB),
        .alu_ctrl    (aluCtrl),
        .alu_result  (aluResult),
        .alu_zero    (aluZero)
    );

    alu #(.N(N)) uAlu (
        .a         (aluA),
        .b         (aluB),
        .ALUControl(aluCtrl),
        .result    (aluResult),
        .zero      (aluZero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of ITER cycles the multiplier should take for a given op_b.
    function automatic int expIters(input logic [N-1:0] b);
        int msb;
        if (!EARLY) return N;
        msb = -1;
        for (int i = 0; i < N; i++) begin
            if (b[i]) msb = i;
        end
        return msb + 1;
    endfunction

    // Issue one operation and watch it to completion, sampling on negedges.
    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit holdStart, output int lat,
                         output logic [N-1:0] prod, output logic pz,
                         output bit sawBusy, output int busyErrs,
                         output int ctrlErrs);
        lat = -1;
        prod = '0;
        pz = 1'b0;
        sawBusy = 1'b0;
        busyErrs = 0;
        ctrlErrs = 0;
        @(negedge clk);
        opA = a;
        opB = b;
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                prod = product;
                pz = productZero;
                if (busy !== 1'b0) busyErrs++;
                break;
            end
            if (busy === 1'b1) begin
                sawBusy = 1'b1;
                if (aluCtrl !== 4'b0010) ctrlErrs++;
            end else begin
                busyErrs++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        opA = '0;
        opB = '0;
        #12;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || productZero !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b product=%h pz=%b, want 0/0/0/0",
                     busy, done, product, productZero);
        end
        testsRun++;
        if (aluA !== '0 || aluB !== '0 || aluCtrl !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_alu_drive: a=%h b=%h ctrl=%b, want 0/0/0000",
                     aluA, aluB, aluCtrl);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bErr, cErr;
        logic [N-1:0] p;
        logic pz;
        bit sb;
        runOp(64'd3, 64'd5, 1'b0, lat, p, pz, sb, bErr, cErr);
        testsRun++;
        if (lat !== (EARLY ? 4 : 65)) begin
            testsFailed++;
            $display("[TB] FAIL basic_latency: got %0d want %0d", lat, EARLY ? 4 : 65);
        end
        testsRun++;
        if (p !== 64'd15 || pz !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_product: got %h/%b want 15/0", p, pz);
        end
        testsRun++;
        if (bErr != 0 || cErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL basic_busy_ctrl: busyErrs=%0d ctrlErrs=%0d want 0/0", bErr, cErr);
        end
        @(negedge clk);
        testsRun++;
        if (done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_wrap();
        int lat, bErr, cErr;
        logic [N-1:0] p;
        logic pz;
        bit sb;
        runOp(64'h8000_0000_0000_0000, 64'd2, 1'b0, lat, p, pz, sb, bErr, cErr);
        testsRun++;
        if (p !== '0 || pz !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_product: got %h/%b want 0/1", p, pz);
        end
        testsRun++;
        if (lat !== expIters(64'd2) + 1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_latency: got %0d want %0d", lat, expIters(64'd2) + 1);
        end
    endtask

    task automatic test_zero_b();
        int lat, bErr, cErr;
        logic [N-1:0] p;
        logic pz;
        bit sb;
        logic [N-1:0] a;
        a = {$urandom, $urandom};
        runOp(a, 64'd0, 1'b0, lat, p, pz, sb, bErr, cErr);
        testsRun++;
        if (lat !== expIters(64'd0) + 1) begin
            testsFailed++;
            $display("[TB] FAIL zero_b_latency: got %0d want %0d", lat, expIters(64'd0) + 1);
        end
        testsRun++;
        if (sb !== (expIters(64'd0) > 0) || bErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL zero_b_busy: sawBusy=%b busyErrs=%0d want %b/0",
                     sb, bErr, expIters(64'd0) > 0);
        end
        testsRun++;
        if (p !== '0 || pz !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL zero_b_product: got %h/%b want 0/1", p, pz);
        end
    endtask

    task automatic test_start_held();
        int lat, bErr, cErr, lat2;
        logic [N-1:0] p, a2, b2, want2;
        logic pz;
        bit sb;
        runOp(64'd7, 64'd9, 1'b1, lat, p, pz, sb, bErr, cErr);
        testsRun++;
        if (p !== 64'd63 || lat !== expIters(64'd9) + 1) begin
            testsFailed++;
            $display("[TB] FAIL held_first: product=%0d lat=%0d want 63/%0d",
                     p, lat, expIters(64'd9) + 1);
        end
        a2 = {$urandom, $urandom};
        b2 = {$urandom, $urandom} >> $urandom_range(0, 60);
        b2[0] = 1'b1;
        want2 = a2 * b2;
        opA = a2;
        opB = b2;
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL held_idle_gap: busy=%b done=%b want 0/0", busy, done);
        end
        lat2 = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                testsRun++;
                if (busy !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL held_reaccept: busy=%b want 1", busy);
                end
            end
            start = 1'b0;
            if (done === 1'b1) begin
                lat2 = c;
                break;
            end
        end
        testsRun++;
        if (lat2 !== expIters(b2) + 1 || product !== want2) begin
            testsFailed++;
            $display("[TB] FAIL held_second: lat=%0d product=%h want %0d/%h",
                     lat2, product, expIters(b2) + 1, want2);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bErr, cErr;
        logic [N-1:0] p;
        logic pz;
        bit sb;
        runOp(64'd2, 64'd3, 1'b0, lat, p, pz, sb, bErr, cErr);
        @(negedge clk);
        opA = 64'hFFFF;
        opB = 64'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        testsRun++;
        if (busy !== 1'b1 || product !== 64'd6) begin
            testsFailed++;
            $display("[TB] FAIL mid_before_reset: busy=%b product=%0d want 1/6", busy, product);
        end
        #3 reset = 1'b1;
        #1;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            testsFailed++;
            $display("[TB] FAIL mid_async_reset: busy=%b done=%b product=%h want 0/0/0",
                     busy, done, product);
        end
        @(negedge clk);
        reset = 1'b0;
        runOp(64'd2, 64'd2, 1'b0, lat, p, pz, sb, bErr, cErr);
        testsRun++;
        if (p !== 64'd4 || lat !== expIters(64'd2) + 1) begin
            testsFailed++;
            $display("[TB] FAIL mid_after_reset: product=%0d lat=%0d want 4/%0d",
                     p, lat, expIters(64'd2) + 1);
        end
    endtask

    task automatic test_random();
        int lat, bErr, cErr;
        logic [N-1:0] p, a, b, want;
        logic pz;
        bit sb;
        for (int k = 0; k < 8; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            want = a * b;
            runOp(a, b, 1'b0, lat, p, pz, sb, bErr, cErr);
            testsRun++;
            if (p !== want || pz !== (want == '0)) begin
                testsFailed++;
                $display("[TB] FAIL random_product[%0d]: %h*%h got %h/%b want %h/%b",
                         k, a, b, p, pz, want, want == '0);
            end
            testsRun++;
            if (lat !== expIters(b) + 1 || bErr != 0 || cErr != 0) begin
                testsFailed++;
                $display("[TB] FAIL random_timing[%0d]: lat=%0d busyErrs=%0d ctrlErrs=%0d want %0d/0/0",
                         k, lat, bErr, cErr, expIters(b) + 1);
            end
        end
    endtask

    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_b();
        test_start_held();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
